uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: decoder state encoding and frame geometry.
// The receiver imports this now; the transmitter will import it later.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. The pointers carry one extra wrap bit so that full and
// empty can be told apart. A push into a full FIFO lands only if a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronized, each bit is sampled at its middle, and good bytes
// are queued in a small FIFO. Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic rx_meta, rx_s, rx_prev;

    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 stop_ok, stop_bad;
    logic                 fifo_full, fifo_empty;
    logic                 tick;

    // History is reset high so that a line held low through reset does not look like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    assign tick = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                // Leaving IDLE needs a fresh falling edge. A held-low line (break) therefore re-arms only after it goes high.
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    cnt_n   = CNT_HALF;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_n   = DATA;
                        cnt_n     = CNT_FULL;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n[bit_idx] = rx_s;
                    cnt_n            = CNT_FULL;
                    if (bit_idx == 3'(DATA_BITS - 1)) state_n = STOP;
                    else bit_idx_n = bit_idx + 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    stop_ok  = rx_s;
                    stop_bad = !rx_s;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stop_ok),
        .push_data (shreg),
        .pop       (rd_ready),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid  = !fifo_empty;
    assign frame_err = stop_bad;
    // A full FIFO is never empty, so a pop can only happen here if rd_ready is high.
    assign overrun   = stop_ok && fifo_full && !rd_ready;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A negedge monitor collects popped bytes and pulse statistics; each test task checks them inline.
module tb_uart_rx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] got [$];
    int   fe_cycles = 0, fe_rises = 0, ov_cycles = 0, ov_rises = 0;
    int   both_cnt = 0, unstable = 0;
    logic fe_d = 1'b0, ov_d = 1'b0, stall_d = 1'b0;
    logic [7:0] data_d = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (rst) begin
            fe_d    = 1'b0;
            ov_d    = 1'b0;
            stall_d = 1'b0;
        end else begin
            if (rd_valid && rd_ready) got.push_back(rd_data);
            if (frame_err) fe_cycles++;
            if (frame_err && !fe_d) fe_rises++;
            if (overrun) ov_cycles++;
            if (overrun && !ov_d) ov_rises++;
            if (frame_err && overrun) both_cnt++;
            if (stall_d && rd_valid && rd_data !== data_d) unstable++;
            fe_d    = frame_err;
            ov_d    = overrun;
            stall_d = rd_valid && !rd_ready;
            data_d  = rd_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; rd_ready = 1'b0;
        tick(3);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_back_to_back;
        int fe0, ov0;
        fe0 = fe_rises; ov0 = ov_rises;
        got.delete();
        rd_ready = 1'b1;
        send(8'h55, 1'b1);
        send(8'hA3, 1'b1);
        tick(6);
        rd_ready = 1'b0;
        checks++; if (got.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", got.size()); end
        checks++; if (got[0] !== 8'h55) begin errors++; $display("FAIL b2b_byte0 got=%h want=55", got[0]); end
        checks++; if (got[1] !== 8'hA3) begin errors++; $display("FAIL b2b_byte1 got=%h want=a3", got[1]); end
        checks++; if (fe_rises != fe0 || ov_rises != ov0) begin
            errors++; $display("FAIL b2b_no_err fe=%0d ov=%0d want 0 0", fe_rises - fe0, ov_rises - ov0);
        end
    endtask

    task automatic test_latency;
        got.delete();
        send(8'h5A, 1'b1);
        // Stop bit is sampled on the next posedge; the byte becomes visible only after it.
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_early got=%b want=0", rd_valid); end
        tick(1);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b want=1", rd_valid); end
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL lat_data got=%h want=5a", rd_data); end
        tick(3);
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL lat_hold got=%h want=5a", rd_data); end
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_pop got=%b want=0", rd_valid); end
        checks++; if (got.size() != 1 || got[0] !== 8'h5A) begin
            errors++; $display("FAIL lat_popped size=%0d byte=%h want 1 5a", got.size(), got[0]);
        end
        rd_ready = 1'b1;
        tick(3);
        rd_ready = 1'b0;
        checks++; if (got.size() != 1) begin errors++; $display("FAIL lat_empty_pop size=%0d want=1", got.size()); end
    endtask

    task automatic test_glitch;
        int fe0;
        fe0 = fe_rises;
        got.delete();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b want=0", rd_valid); end
        checks++; if (fe_rises != fe0) begin errors++; $display("FAIL glitch_ferr got=%0d want=0", fe_rises - fe0); end
        rd_ready = 1'b1;
        send(8'hC3, 1'b1);
        tick(4);
        rd_ready = 1'b0;
        checks++; if (got.size() != 1 || got[0] !== 8'hC3) begin
            errors++; $display("FAIL glitch_next size=%0d byte=%h want 1 c3", got.size(), got[0]);
        end
    endtask

    task automatic test_frame_err;
        int fe0, fc0;
        fe0 = fe_rises; fc0 = fe_cycles;
        send(8'hA5, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got=%b want=1", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ferr_no_ovr got=%b want=0", overrun); end
        tick(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got=%b want=0", frame_err); end
        tick(4);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got=%b want=0", rd_valid); end
        checks++; if (fe_rises != fe0 + 1 || fe_cycles != fc0 + 1) begin
            errors++; $display("FAIL ferr_count rises=%0d cycles=%0d want 1 1", fe_rises - fe0, fe_cycles - fc0);
        end
    endtask

    task automatic test_break;
        int fe0;
        fe0 = fe_rises;
        rx = 1'b0;
        tick(120);
        rx = 1'b1;
        tick(10);
        checks++; if (fe_rises != fe0 + 1) begin errors++; $display("FAIL break_ferr got=%0d want=1", fe_rises - fe0); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL break_valid got=%b want=0", rd_valid); end
    endtask

    task automatic test_overrun;
        int ov0, oc0;
        ov0 = ov_rises; oc0 = ov_cycles;
        got.delete();
        rd_ready = 1'b0;
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b1);
        tick(2);
        checks++; if (ov_rises != ov0 + 1 || ov_cycles != oc0 + 1) begin
            errors++; $display("FAIL ovr_pulse rises=%0d cycles=%0d want 1 1", ov_rises - ov0, ov_cycles - oc0);
        end
        checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL ovr_head got=%h want=01", rd_data); end
        rd_ready = 1'b1;
        tick(8);
        rd_ready = 1'b0;
        checks++; if (got.size() != 4) begin errors++; $display("FAIL ovr_count got=%0d want=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_order[%0d] got=%h want=%h", i, got[i], 8'(i + 1)); end
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got=%b want=0", rd_valid); end
    endtask

    task automatic test_full_pop;
        int ov0;
        logic [7:0] exp_q [5];
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h77};
        ov0 = ov_rises;
        got.delete();
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(exp_q[i], 1'b1);
        send(8'h77, 1'b1);
        // The next posedge samples the stop bit of 0x77 while the FIFO is full; pop on that same edge.
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        checks++; if (ov_rises != ov0) begin errors++; $display("FAIL fullpop_ovr got=%0d want=0", ov_rises - ov0); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fullpop_head got=%h want=11", rd_data); end
        rd_ready = 1'b1;
        tick(8);
        rd_ready = 1'b0;
        checks++; if (got.size() != 5) begin errors++; $display("FAIL fullpop_count got=%0d want=5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_order[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int fe0, ov0;
        fe0 = fe_rises; ov0 = ov_rises;
        got.delete();
        rd_ready = 1'b0;
        send(8'h99, 1'b1);
        tick(3);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB * 3);
        rst = 1'b1;
        tick(2);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h want=00", rd_data); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rstmid_pulses fe=%b ov=%b want 0 0", frame_err, overrun);
        end
        rst = 1'b0;
        tick(60);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_nopush got=%b want=0", rd_valid); end
        checks++; if (fe_rises != fe0 || ov_rises != ov0) begin
            errors++; $display("FAIL rstmid_silent fe=%0d ov=%0d want 0 0", fe_rises - fe0, ov_rises - ov0);
        end
        send(8'h3C, 1'b1);
        tick(1);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
            errors++; $display("FAIL rstmid_next valid=%b data=%h want 1 3c", rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        tick(2);
        rd_ready = 1'b0;
        checks++; if (got.size() != 1 || got[0] !== 8'h3C) begin
            errors++; $display("FAIL rstmid_popped size=%0d byte=%h want 1 3c", got.size(), got[0]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_latency();
        test_glitch();
        test_frame_err();
        test_break();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL err_exclusive got=%0d want=0", both_cnt); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL data_stable got=%0d want=0", unstable); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
